dcache_l2_bridge: RTL and testbench

- Sits directly downstream of the dcache controller, between the dcache and the L2/memory port.
- Converts the controller's block-level request into per-word memory transactions:
  - block address plus LOAD (refill) or STORE (writeback) type in;
  - word-by-word valid/ready requests out.
- Returns a one-cycle `l2_fetched_word_valid` pulse per refill word and a one-cycle `l2_store_ack` pulse per written-back word. These drive the controller's counter decrement.

---
 rtl/xentry_pkg.sv | 25 ++
 rtl/dcache_l2_bridge_if.sv | 41 ++++
 rtl/dcache_l2_timeout.sv | 42 ++++
 rtl/dcache_l2_bridge.sv | 181 ++++++++++++++++++
 tb/tb_dcache_l2_bridge.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xentry_pkg.sv
// ---------------------------------------------------------------------------
// xentry_pkg : shared dcache types, bridge FSM states and block geometry. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package xentry_pkg;

  typedef enum logic [1:0] {
    LOAD       = 2'd0,
    STORE      = 2'd1,
    MO_UNKNOWN = 2'd2
  } memory_operation_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } l2_bridge_state_e;

  localparam int DCACHE_WORDS_PER_BLOCK = 4;

endpackage

`default_nettype wire

// File: rtl/dcache_l2_bridge_if.sv
// ---------------------------------------------------------------------------
// dcache_l2_bridge_if : word-level memory request/response port. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dcache_l2_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [XLEN-1:0]   mem_req_wdata;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_rdata;

  modport master (
    output mem_req_valid,
    output mem_req_we,
    output mem_req_addr,
    output mem_req_wdata,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_we,
    input  mem_req_addr,
    input  mem_req_wdata,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_rdata
  );

endinterface

`default_nettype wire

// File: rtl/dcache_l2_timeout.sv
// ---------------------------------------------------------------------------
// dcache_l2_timeout : response watchdog with sticky error flag. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_l2_timeout #(
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic wait_active,
  input  logic resp_valid,
  output logic expired,
  output logic timeout_err
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Leaving the wait state or seeing a response restarts the count from zero.
  always_comb begin
    expired = wait_active && !resp_valid && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d   = (wait_active && !resp_valid && !expired) ? cnt_q + CNT_W'(1) : '0;
    err_d   = err_q | expired;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;

endmodule

`default_nettype wire

// File: rtl/dcache_l2_bridge.sv
// ---------------------------------------------------------------------------
// dcache_l2_bridge : splits dcache block refill/writeback into word requests. Rev 1.0
// Optional: define DCACHE_L2_BRIDGE_TIMEOUT_EN for the response watchdog.
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_l2_bridge
  import xentry_pkg::*;
#(
  parameter  int ADDR_W          = 32,
  parameter  int XLEN            = 32,
  parameter  int WORDS_PER_BLOCK = DCACHE_WORDS_PER_BLOCK,
  parameter  int TIMEOUT_CYCLES  = 64,
  localparam int IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               l2_req_valid,
  input  memory_operation_e  l2_req_type,
  input  logic [ADDR_W-1:0]  l2_block_addr,
  input  logic [XLEN-1:0]    l2_store_word,
  output logic [IDX_W-1:0]   l2_word_index,
  output logic               l2_fetched_word_valid,
  output logic [XLEN-1:0]    l2_fetched_word,
  output logic               l2_store_ack,
  output logic               l2_timeout_err,
  dcache_l2_bridge_if.master mem
);

  localparam int               BYTE_SHIFT = $clog2(XLEN / 8);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORDS_PER_BLOCK - 1);

  l2_bridge_state_e  state_q, state_d;
  memory_operation_e type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              abort_q, abort_d;
  logic              fetched_valid_q, fetched_valid_d;
  logic [XLEN-1:0]   fetched_word_q, fetched_word_d;
  logic              store_ack_q, store_ack_d;

  logic [ADDR_W-1:0] word_offset;
  logic              abort_now;
  logic              timeout_hit;

  assign word_offset = ADDR_W'(idx_q) << BYTE_SHIFT;
  // A drop of l2_req_valid is remembered so the in-flight word finishes silently.
  assign abort_now   = abort_q || !l2_req_valid;

`ifdef DCACHE_L2_BRIDGE_TIMEOUT_EN
  dcache_l2_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk         (clk),
    .reset_n     (reset_n),
    .wait_active (state_q == ST_WAIT),
    .resp_valid  (mem.mem_resp_valid),
    .expired     (timeout_hit),
    .timeout_err (l2_timeout_err)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign l2_timeout_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    type_d          = type_q;
    addr_d          = addr_q;
    idx_d           = idx_q;
    abort_d         = abort_q;
    fetched_valid_d = 1'b0;
    fetched_word_d  = fetched_word_q;
    store_ack_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (l2_req_valid) begin
          type_d  = l2_req_type;
          addr_d  = l2_block_addr;
          idx_d   = '0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (!l2_req_valid) abort_d = 1'b1;
        if (mem.mem_req_ready) state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (!l2_req_valid) abort_d = 1'b1;
        if (mem.mem_resp_valid) begin
          if (abort_now) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            if (type_q == LOAD) begin
              fetched_valid_d = 1'b1;
              fetched_word_d  = mem.mem_resp_rdata;
            end
            if (type_q == STORE) store_ack_d = 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = ST_ISSUE;
            end
          end
        end else if (timeout_hit) begin
          state_d = ST_ISSUE;
        end
      end

      ST_DONE: begin
        // Held request of the same type is the tail of the finished block;
        // a type change chains straight into the next block.
        if (!l2_req_valid) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else if (l2_req_type != type_q) begin
          type_d  = l2_req_type;
          addr_d  = l2_block_addr;
          idx_d   = '0;
          state_d = ST_ISSUE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      type_q          <= LOAD;
      addr_q          <= '0;
      idx_q           <= '0;
      abort_q         <= 1'b0;
      fetched_valid_q <= 1'b0;
      fetched_word_q  <= '0;
      store_ack_q     <= 1'b0;
    end else begin
      type_q          <= type_d;
      addr_q          <= addr_d;
      idx_q           <= idx_d;
      abort_q         <= abort_d;
      fetched_valid_q <= fetched_valid_d;
      fetched_word_q  <= fetched_word_d;
      store_ack_q     <= store_ack_d;
    end
  end

  always_comb begin
    mem.mem_req_valid = 1'b0;
    mem.mem_req_we    = 1'b0;
    mem.mem_req_addr  = '0;
    mem.mem_req_wdata = '0;
    if (state_q == ST_ISSUE) begin
      mem.mem_req_valid = 1'b1;
      mem.mem_req_we    = (type_q == STORE);
      mem.mem_req_addr  = addr_q + word_offset;
      mem.mem_req_wdata = l2_store_word;
    end
    l2_word_index         = idx_q;
    l2_fetched_word_valid = fetched_valid_q;
    l2_fetched_word       = fetched_word_q;
    l2_store_ack          = store_ack_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_l2_bridge.sv
// ---------------------------------------------------------------------------
// tb_dcache_l2_bridge : randomized bench with memory responder and block model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dcache_l2_bridge;
  import xentry_pkg::*;

  localparam int WPB = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              l2_req_valid = 1'b0;
  memory_operation_e l2_req_type = LOAD;
  logic [31:0]       l2_block_addr = '0;
  logic [31:0]       l2_store_word;
  logic [1:0]        l2_word_index;
  logic              l2_fetched_word_valid;
  logic [31:0]       l2_fetched_word;
  logic              l2_store_ack;
  logic              l2_timeout_err;
  logic [31:0]       store_data [WPB];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Memory responder knobs and observation logs.
  int          resp_delay = 0;
  bit          rand_delay = 1'b0;
  int          stall_at = -1;
  int          stall_len = 0;
  int          stall_seen = 0;
  int          drop_at = -1;
  int          unstable = 0;
  bit          pending = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_data;
  req_t        hold;
  req_t        req_log[$];
  logic [31:0] resp_log[$];
  logic [31:0] fetch_log[$];
  int          fetch_cyc[$];
  int          ack_cnt = 0;

  assign l2_store_word = store_data[l2_word_index];

  dcache_l2_bridge_if #(.ADDR_W(32), .XLEN(32)) mem_if ();

  dcache_l2_bridge #(
    .ADDR_W(32), .XLEN(32), .WORDS_PER_BLOCK(WPB), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .l2_req_valid          (l2_req_valid),
    .l2_req_type           (l2_req_type),
    .l2_block_addr         (l2_block_addr),
    .l2_store_word         (l2_store_word),
    .l2_word_index         (l2_word_index),
    .l2_fetched_word_valid (l2_fetched_word_valid),
    .l2_fetched_word       (l2_fetched_word),
    .l2_store_ack          (l2_store_ack),
    .l2_timeout_err        (l2_timeout_err),
    .mem                   (mem_if)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    req_t r;
    int   n;
    mem_if.mem_req_ready  = 1'b0;
    mem_if.mem_resp_valid = 1'b0;
    mem_if.mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_if.mem_resp_valid = 1'b0;
      mem_if.mem_req_ready  = 1'b0;
      if (pending) begin
        if (pend_cnt == 0) begin
          mem_if.mem_resp_valid = 1'b1;
          mem_if.mem_resp_rdata = pend_data;
          resp_log.push_back(pend_data);
          pending = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (mem_if.mem_req_valid === 1'b1 && !pending && !mem_if.mem_resp_valid) begin
        r.addr  = mem_if.mem_req_addr;
        r.we    = mem_if.mem_req_we;
        r.wdata = mem_if.mem_req_wdata;
        n       = req_log.size();
        if (n == stall_at && stall_seen < stall_len) begin
          if (stall_seen == 0) hold = r;
          else if (r !== hold) unstable++;
          stall_seen++;
        end else begin
          if (n == stall_at && stall_seen > 0 && r !== hold) unstable++;
          mem_if.mem_req_ready = 1'b1;
          req_log.push_back(r);
          if (n != drop_at) begin
            pending   = 1'b1;
            pend_cnt  = rand_delay ? int'($urandom_range(0, 3)) : resp_delay;
            pend_data = $urandom;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (l2_fetched_word_valid === 1'b1) begin
      fetch_log.push_back(l2_fetched_word);
      fetch_cyc.push_back(cyc);
    end
    if (l2_store_ack === 1'b1) ack_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not finish, required finish");
    $fatal(1, "global watchdog");
  end

  task automatic clear_logs();
    req_log.delete();
    resp_log.delete();
    fetch_log.delete();
    fetch_cyc.delete();
    ack_cnt    = 0;
    stall_seen = 0;
    unstable   = 0;
    for (int i = 0; i < WPB; i++) store_data[i] = $urandom;
  endtask

  task automatic wait_pulses(input int n, input bit is_load, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if ((is_load ? fetch_log.size() : ack_cnt) >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_reqs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (req_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_block(input memory_operation_e t, input logic [31:0] a);
    @(posedge clk); #1;
    l2_req_type   = t;
    l2_block_addr = a;
    l2_req_valid  = 1'b1;
  endtask

  task automatic end_block();
    @(posedge clk); #1;
    l2_req_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem_if.mem_req_valid !== 1'b0 || mem_if.mem_req_we !== 1'b0 ||
        mem_if.mem_req_addr !== 32'h0 || mem_if.mem_req_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem_port: valid=%b we=%b addr=%h wdata=%h required all zero",
               mem_if.mem_req_valid, mem_if.mem_req_we, mem_if.mem_req_addr, mem_if.mem_req_wdata);
    end
    checks++;
    if (l2_word_index !== 2'd0 || l2_fetched_word_valid !== 1'b0 || l2_fetched_word !== 32'h0 ||
        l2_store_ack !== 1'b0 || l2_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl_port: idx=%0d fv=%b fw=%h ack=%b err=%b required all zero",
               l2_word_index, l2_fetched_word_valid, l2_fetched_word, l2_store_ack, l2_timeout_err);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_load();
    bit ok;
    int start;
    clear_logs();
    resp_delay = 0;
    start_block(LOAD, 32'h1000);
    checks++;
    if (mem_if.mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_latency0: mem_req_valid=%b required 0", mem_if.mem_req_valid);
    end
    @(posedge clk); #1;
    start = cyc;
    checks++;
    if (mem_if.mem_req_valid !== 1'b1 || mem_if.mem_req_addr !== 32'h1000 || mem_if.mem_req_we !== 1'b0) begin
      errors++;
      $display("FAIL load_latency1: valid=%b addr=%h we=%b required 1 00001000 0",
               mem_if.mem_req_valid, mem_if.mem_req_addr, mem_if.mem_req_we);
    end
    wait_pulses(4, 1'b1, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL load_pulses: got %0d pulses required 4", fetch_log.size());
    end else begin
      for (int i = 0; i < WPB; i++) begin
        checks++;
        if (req_log[i].addr !== 32'h1000 + 32'(i * 4) || req_log[i].we !== 1'b0 ||
            fetch_log[i] !== resp_log[i]) begin
          errors++;
          $display("FAIL load_word%0d: addr=%h we=%b data=%h required addr=%h we=0 data=%h",
                   i, req_log[i].addr, req_log[i].we, fetch_log[i], 32'h1000 + 32'(i * 4), resp_log[i]);
        end
      end
      checks++;
      if (fetch_cyc[3] - start != 8) begin
        errors++;
        $display("FAIL load_throughput: last pulse at +%0d cycles required +8", fetch_cyc[3] - start);
      end
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (req_log.size() != 4 || fetch_log.size() != 4 || mem_if.mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_done_hold: reqs=%0d pulses=%0d valid=%b required 4 4 0",
               req_log.size(), fetch_log.size(), mem_if.mem_req_valid);
    end
    end_block();
  endtask

  task automatic test_store_then_load();
    bit ok;
    clear_logs();
    start_block(STORE, 32'h2000);
    wait_pulses(4, 1'b0, 100, ok);
    l2_req_type   = LOAD;
    l2_block_addr = 32'h3000;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL chain_store_acks: got %0d acks required 4", ack_cnt);
    end
    wait_pulses(4, 1'b1, 100, ok);
    checks++;
    if (!ok || req_log.size() != 8 || ack_cnt != 4) begin
      errors++;
      $display("FAIL chain_counts: reqs=%0d acks=%0d pulses=%0d required 8 4 4",
               req_log.size(), ack_cnt, fetch_log.size());
    end else begin
      for (int i = 0; i < WPB; i++) begin
        checks++;
        if (req_log[i].addr !== 32'h2000 + 32'(i * 4) || req_log[i].we !== 1'b1 ||
            req_log[i].wdata !== store_data[i]) begin
          errors++;
          $display("FAIL chain_store%0d: addr=%h we=%b wdata=%h required addr=%h we=1 wdata=%h",
                   i, req_log[i].addr, req_log[i].we, req_log[i].wdata, 32'h2000 + 32'(i * 4), store_data[i]);
        end
        checks++;
        if (req_log[i+4].addr !== 32'h3000 + 32'(i * 4) || req_log[i+4].we !== 1'b0 ||
            fetch_log[i] !== resp_log[i+4]) begin
          errors++;
          $display("FAIL chain_load%0d: addr=%h we=%b data=%h required addr=%h we=0 data=%h",
                   i, req_log[i+4].addr, req_log[i+4].we, fetch_log[i], 32'h3000 + 32'(i * 4), resp_log[i+4]);
        end
      end
    end
    end_block();
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] base;
    clear_logs();
    base      = {$urandom, 4'h0};
    stall_at  = 2;
    stall_len = 5;
    start_block(STORE, base);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (stall_seen >= 5) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || ack_cnt != 2) begin
      errors++;
      $display("FAIL stall_no_early_ack: stalled=%0d acks=%0d required 5 2", stall_seen, ack_cnt);
    end
    wait_pulses(4, 1'b0, 100, ok);
    checks++;
    if (!ok || unstable != 0 || req_log.size() != 4) begin
      errors++;
      $display("FAIL stall_stable: acks=%0d unstable=%0d reqs=%0d required 4 0 4",
               ack_cnt, unstable, req_log.size());
    end else begin
      checks++;
      if (req_log[2].addr !== base + 32'd8 || req_log[2].we !== 1'b1 || req_log[2].wdata !== store_data[2]) begin
        errors++;
        $display("FAIL stall_word2: addr=%h we=%b wdata=%h required addr=%h we=1 wdata=%h",
                 req_log[2].addr, req_log[2].we, req_log[2].wdata, base + 32'd8, store_data[2]);
      end
    end
    stall_at = -1;
    end_block();
  endtask

  task automatic test_abort();
    bit ok;
    logic [31:0] base;
    clear_logs();
    resp_delay = 2;
    start_block(LOAD, 32'h4000);
    wait_reqs(2, 100, ok);
    @(posedge clk); #1;
    l2_req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (!ok || fetch_log.size() != 1 || req_log.size() != 2 || resp_log.size() != 2) begin
      errors++;
      $display("FAIL abort_suppress: pulses=%0d reqs=%0d resps=%0d required 1 2 2",
               fetch_log.size(), req_log.size(), resp_log.size());
    end
    clear_logs();
    resp_delay = 0;
    base = 32'h4100;
    start_block(LOAD, base);
    wait_pulses(4, 1'b1, 100, ok);
    checks++;
    if (!ok || req_log[0].addr !== base || fetch_log[3] !== resp_log[3]) begin
      errors++;
      $display("FAIL abort_restart: pulses=%0d first_addr=%h required 4 %h",
               fetch_log.size(), req_log[0].addr, base);
    end
    end_block();
  endtask

  task automatic test_reset_midway();
    bit ok;
    logic [31:0] base;
    clear_logs();
    resp_delay = 4;
    start_block(LOAD, 32'h5000);
    wait_reqs(2, 100, ok);
    @(posedge clk); #2;
    reset_n      = 1'b0;
    l2_req_valid = 1'b0;
    #1;
    checks++;
    if (!ok || mem_if.mem_req_valid !== 1'b0 || l2_word_index !== 2'd0 ||
        l2_fetched_word !== 32'h0 || l2_fetched_word_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: valid=%b idx=%0d fw=%h fv=%b required all zero",
               mem_if.mem_req_valid, l2_word_index, l2_fetched_word, l2_fetched_word_valid);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 20 && resp_log.size() < 2; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fetch_log.size() != 1 || resp_log.size() != 2) begin
      errors++;
      $display("FAIL reset_late_resp: pulses=%0d resps=%0d required 1 2", fetch_log.size(), resp_log.size());
    end
    clear_logs();
    resp_delay = 0;
    base = 32'h5200;
    start_block(LOAD, base);
    wait_pulses(4, 1'b1, 100, ok);
    checks++;
    if (!ok || req_log[0].addr !== base || req_log[3].addr !== base + 32'd12) begin
      errors++;
      $display("FAIL reset_restart: pulses=%0d first_addr=%h required 4 %h",
               fetch_log.size(), req_log[0].addr, base);
    end
    end_block();
  endtask

  task automatic test_random_blocks();
    bit ok;
    bit is_load;
    logic [31:0] base;
    rand_delay = 1'b1;
    for (int b = 0; b < 8; b++) begin
      clear_logs();
      base      = (b == 0) ? 32'hFFFF_FFF0 : {$urandom, 4'h0};
      is_load   = $urandom_range(0, 1) == 1;
      stall_at  = $urandom_range(0, 3);
      stall_len = $urandom_range(0, 3);
      start_block(is_load ? LOAD : STORE, base);
      wait_pulses(4, is_load, 200, ok);
      checks++;
      if (!ok || req_log.size() != 4 || unstable != 0) begin
        errors++;
        $display("FAIL rand%0d_count: reqs=%0d pulses=%0d acks=%0d unstable=%0d required 4 words",
                 b, req_log.size(), fetch_log.size(), ack_cnt, unstable);
      end else begin
        for (int i = 0; i < WPB; i++) begin
          checks++;
          if (req_log[i].addr !== base + 32'(i * 4) || req_log[i].we !== !is_load ||
              (is_load ? (fetch_log[i] !== resp_log[i]) : (req_log[i].wdata !== store_data[i]))) begin
            errors++;
            $display("FAIL rand%0d_word%0d: addr=%h we=%b wdata=%h required addr=%h we=%b",
                     b, i, req_log[i].addr, req_log[i].we, req_log[i].wdata, base + 32'(i * 4), !is_load);
          end
        end
      end
      end_block();
    end
    rand_delay = 1'b0;
    stall_at   = -1;
  endtask

`ifdef DCACHE_L2_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    logic [31:0] base;
    clear_logs();
    base    = 32'h6000;
    drop_at = 0;
    start_block(LOAD, base);
    wait_reqs(1, 100, ok);
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (!ok || l2_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: err=%b required 0", l2_timeout_err);
    end
    @(posedge clk); #1;
    checks++;
    if (l2_timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_rise: err=%b required 1", l2_timeout_err);
    end
    drop_at = -1;
    wait_pulses(4, 1'b1, 100, ok);
    checks++;
    if (!ok || req_log.size() != 5 || req_log[1].addr !== base || req_log[4].addr !== base + 32'd12 ||
        fetch_log[0] !== resp_log[0] || l2_timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_reissue: reqs=%0d pulses=%0d addr1=%h err=%b required 5 4 %h 1",
               req_log.size(), fetch_log.size(), req_log[1].addr, l2_timeout_err, base);
    end
    end_block();
  endtask
`endif

  initial begin
    for (int i = 0; i < WPB; i++) store_data[i] = '0;
    test_reset();
    test_load();
    test_store_then_load();
    test_stall();
    test_abort();
    test_reset_midway();
    test_random_blocks();
`ifdef DCACHE_L2_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
